// File: rtl/led_pwm_pkg.sv
// Shared definitions for the multi-channel LED PWM controller:
// channel mode encodings, default widths and the per-channel output select.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    LED_MODE_OFF   = 2'b00,
    LED_MODE_ON    = 2'b01,
    LED_MODE_BLINK = 2'b10,
    LED_MODE_PWM   = 2'b11
  } led_mode_e;

  localparam int LED_NUM_DEF       = 4;
  localparam int PWM_BITS_DEF      = 8;
  localparam int PRESCALE_BITS_DEF = 16;
  localparam int BLINK_BITS_DEF    = 16;

  // Picks the lamp value for one channel from its mode and the shared sources.
  function automatic logic led_select(input led_mode_e mode,
                                      input logic blink_phase,
                                      input logic pwm_lit);
    logic lit;
    lit = 1'b0;
    case (mode)
      LED_MODE_OFF:   lit = 1'b0;
      LED_MODE_ON:    lit = 1'b1;
      LED_MODE_BLINK: lit = blink_phase;
      LED_MODE_PWM:   lit = pwm_lit;
      default:        lit = 1'b0;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: duty latch (updated only on the PWM wrap tick), optional
// breathe ramp (LED_PWM_BREATHE_EN), mode mux and registered LED output.
// All decisions use the post-tick counter values handed in by the top level,
// so a mode change and a tick on the same cycle see the new counters.
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] pwm_cnt_next,
  input  logic                blink_phase_next,
  output logic                led
);

  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_next;
  logic [PWM_BITS-1:0] level_next;
  logic                led_next;

  // New duty is only taken at the period boundary so periods never glitch.
  always_comb begin
    duty_next = duty_q;
    if (wrap) begin
      duty_next = duty;
    end
  end

`ifdef LED_PWM_BREATHE_EN
  logic [PWM_BITS-1:0] level_q;
  logic                ramp_down_q;
  logic                ramp_down_next;

  // Breathe ramp: one step per period, up to the latched duty and back to 0;
  // a new duty value restarts the ramp from dark.
  always_comb begin
    level_next     = level_q;
    ramp_down_next = ramp_down_q;
    if (wrap) begin
      if (duty != duty_q) begin
        level_next     = '0;
        ramp_down_next = 1'b0;
      end else if (!ramp_down_q) begin
        if (level_q < duty_q) begin
          level_next = level_q + 1'b1;
        end else begin
          ramp_down_next = 1'b1;
          if (level_q != '0) begin
            level_next = level_q - 1'b1;
          end
        end
      end else begin
        if (level_q != '0) begin
          level_next = level_q - 1'b1;
        end else begin
          ramp_down_next = 1'b0;
          if (duty_q != '0) begin
            level_next = level_q + 1'b1;
          end
        end
      end
    end
  end

  // Ramp state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q     <= '0;
      ramp_down_q <= 1'b0;
    end else begin
      level_q     <= level_next;
      ramp_down_q <= ramp_down_next;
    end
  end
`else
  assign level_next = duty_next;
`endif

  // Mode mux; PWM is lit while the counter is below the effective level.
  always_comb begin
    led_next = led_select(led_mode_e'(mode), blink_phase_next,
                          (pwm_cnt_next < level_next));
  end

  // Duty latch and registered LED drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q <= '0;
      led    <= 1'b0;
    end else begin
      duty_q <= duty_next;
      led    <= led_next;
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver top level. Holds the shared prescaler, PWM counter,
// blink counter and pwm_sync so every channel stays phase-aligned, and
// instantiates one led_pwm_chan per LED. Define LED_PWM_BREATHE_EN to turn
// PWM mode into a breathing ramp (handled inside led_pwm_chan).
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int LED_NUM       = LED_NUM_DEF,
  parameter int PWM_BITS      = PWM_BITS_DEF,
  parameter int PRESCALE_BITS = PRESCALE_BITS_DEF,
  parameter int BLINK_BITS    = BLINK_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2*LED_NUM-1:0]         led_mode,
  input  logic [LED_NUM*PWM_BITS-1:0]  led_duty,
  input  logic [PRESCALE_BITS-1:0]     tick_div,
  input  logic [BLINK_BITS-1:0]        blink_half,
  output logic [LED_NUM-1:0]           led,
  output logic                         pwm_sync
);

  logic [PRESCALE_BITS-1:0] presc_cnt;
  logic [PRESCALE_BITS-1:0] presc_cnt_next;
  logic                     tick;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic [PWM_BITS-1:0]      pwm_cnt_next;
  logic                     wrap;
  logic [BLINK_BITS-1:0]    blink_cnt;
  logic [BLINK_BITS-1:0]    blink_cnt_next;
  logic                     blink_phase;
  logic                     blink_phase_next;

  // Shared timebase: prescaler tick, PWM counter with wrap, blink half-period.
  // Using >= on the prescaler means a lowered divisor ticks at once.
  always_comb begin
    tick             = (presc_cnt >= tick_div);
    presc_cnt_next   = tick ? '0 : presc_cnt + 1'b1;
    pwm_cnt_next     = pwm_cnt;
    wrap             = 1'b0;
    blink_cnt_next   = blink_cnt;
    blink_phase_next = blink_phase;
    if (tick) begin
      pwm_cnt_next = pwm_cnt + 1'b1;
      wrap         = (pwm_cnt == '1);
      if (blink_cnt >= blink_half) begin
        blink_cnt_next   = '0;
        blink_phase_next = ~blink_phase;
      end else begin
        blink_cnt_next = blink_cnt + 1'b1;
      end
    end
  end

  // Shared counter registers; blink starts in its lit half.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt   <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      pwm_sync    <= 1'b0;
    end else begin
      presc_cnt   <= presc_cnt_next;
      pwm_cnt     <= pwm_cnt_next;
      blink_cnt   <= blink_cnt_next;
      blink_phase <= blink_phase_next;
      pwm_sync    <= wrap;
    end
  end

  for (genvar i = 0; i < LED_NUM; i++) begin : g_chan
    led_pwm_chan #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .clk              (clk),
      .reset            (reset),
      .mode             (led_mode[2*i +: 2]),
      .duty             (led_duty[i*PWM_BITS +: PWM_BITS]),
      .wrap             (wrap),
      .pwm_cnt_next     (pwm_cnt_next),
      .blink_phase_next (blink_phase_next),
      .led              (led[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl (default build, breathe disabled).
// A reference model derives the expected outputs after each clk edge from
// the elapsed tick count and pushes them to a queue; a monitor on the
// falling edge pops and compares against the DUT.
module tb_led_pwm_ctrl;

  localparam int LED_NUM       = 4;
  localparam int PWM_BITS      = 8;
  localparam int PRESCALE_BITS = 16;
  localparam int BLINK_BITS    = 16;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [2*LED_NUM-1:0]        led_mode = 8'h55;
  logic [LED_NUM*PWM_BITS-1:0] led_duty = '0;
  logic [PRESCALE_BITS-1:0]    tick_div = '0;
  logic [BLINK_BITS-1:0]       blink_half = '0;
  logic [LED_NUM-1:0]          led;
  logic                        pwm_sync;

  typedef struct packed {
    logic [LED_NUM-1:0] led;
    logic               sync;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          passes = 0;
  int unsigned edges_since_reset = 0;
  int unsigned latched[LED_NUM];

  led_pwm_ctrl #(
    .LED_NUM(LED_NUM),
    .PWM_BITS(PWM_BITS),
    .PRESCALE_BITS(PRESCALE_BITS),
    .BLINK_BITS(BLINK_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .led_mode   (led_mode),
    .led_duty   (led_duty),
    .tick_div   (tick_div),
    .blink_half (blink_half),
    .led        (led),
    .pwm_sync   (pwm_sync)
  );

  always #5 clk = ~clk;

  // Reference model: with a fixed divisor D and half-period H, tick k lands
  // on edge k*(D+1); PWM count is ticks mod 256; blink phase flips every
  // H+1 ticks starting lit.
  always @(posedge clk) begin
    exp_t        e;
    int unsigned t;
    int unsigned pc;
    bit          is_tick;
    bit          phase;
    e = '0;
    if (reset) begin
      edges_since_reset = 0;
      for (int i = 0; i < LED_NUM; i++) latched[i] = 0;
    end else begin
      edges_since_reset++;
      is_tick = (edges_since_reset % (int'(tick_div) + 1)) == 0;
      t       = edges_since_reset / (int'(tick_div) + 1);
      pc      = t % (1 << PWM_BITS);
      if (is_tick && pc == 0) begin
        for (int i = 0; i < LED_NUM; i++) latched[i] = led_duty[i*PWM_BITS +: PWM_BITS];
      end
      phase  = ((t / (int'(blink_half) + 1)) % 2) == 0;
      e.sync = is_tick && (pc == 0);
      for (int i = 0; i < LED_NUM; i++) begin
        case (led_mode[2*i +: 2])
          2'b00:   e.led[i] = 1'b0;
          2'b01:   e.led[i] = 1'b1;
          2'b10:   e.led[i] = phase;
          default: e.led[i] = (pc < latched[i]);
        endcase
      end
    end
    sb_q.push_back(e);
  end

  task automatic checkOutput(input exp_t e);
    checks++;
    if (led === e.led) passes++;
    else $display("[TB] FAIL led at %0t: got %b, expected %b", $time, led, e.led);
    checks++;
    if (pwm_sync === e.sync) passes++;
    else $display("[TB] FAIL pwm_sync at %0t: got %b, expected %b", $time, pwm_sync, e.sync);
  endtask

  // Monitor: compares every registered output set against the model.
  always @(negedge clk) begin
    if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
  end

  task automatic applyStimulus(input logic [2*LED_NUM-1:0] mode,
                               input logic [LED_NUM*PWM_BITS-1:0] duty,
                               input logic [PRESCALE_BITS-1:0] div,
                               input logic [BLINK_BITS-1:0] half,
                               input int cycles);
    led_mode   = mode;
    led_duty   = duty;
    tick_div   = div;
    blink_half = half;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [PWM_BITS-1:0] randDuty();
    int unsigned r;
    r = $urandom % 4;
    if (r == 0) return '0;
    if (r == 1) return '1;
    return PWM_BITS'($urandom);
  endfunction

  initial begin
    logic [LED_NUM*PWM_BITS-1:0] d;
    logic [PRESCALE_BITS-1:0]    div;
    logic [BLINK_BITS-1:0]       half;

    // Reset with every channel on, then release.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    // Static off/on pattern.
    doReset(2);
    applyStimulus(8'b00_01_00_01, '0, 16'd0, 16'd0, 1000);

    // Blink on channel 0, 5 clk per half.
    doReset(2);
    applyStimulus(8'b00_00_00_10, '0, 16'd0, 16'd4, 200);

    // PWM with duty 64, 0, 255, 128 at two clk per tick.
    doReset(2);
    applyStimulus(8'hFF, {8'd128, 8'd255, 8'd0, 8'd64}, 16'd1, 16'd0, 1600);

    // Mid-period duty write 64 -> 192 at pwm count 100 of the second period.
    doReset(2);
    applyStimulus(8'b00_00_00_11, {24'd0, 8'd64}, 16'd1, 16'd0, 712);
    applyStimulus(8'b00_00_00_11, {24'd0, 8'd192}, 16'd1, 16'd0, 1400);

    // Randomised segments, each with a fixed timebase.
    for (int seg = 0; seg < 6; seg++) begin
      doReset(1 + int'($urandom % 3));
      div  = PRESCALE_BITS'($urandom_range(0, 3));
      half = BLINK_BITS'($urandom_range(0, 7));
      for (int k = 0; k < 16; k++) begin
        for (int c = 0; c < LED_NUM; c++) d[c*PWM_BITS +: PWM_BITS] = randDuty();
        applyStimulus(8'($urandom), d, div, half, int'($urandom_range(50, 150)));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
